// File: rtl/regfile_arbiter.sv
// Round-robin two-requester sequencer for the 16x16 register file: IDLE -> ACCESS -> DONE per access.
// Define RF_ARB_FIXED_PRIO_EN for fixed priority (requester 0 always wins).
module regfile_arbiter #(
    parameter int DW = 16,
    parameter int AW = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ0,
    input  logic          REQ1,
    input  logic          WE0,
    input  logic          WE1,
    input  logic [AW-1:0] ADDRA0,
    input  logic [AW-1:0] ADDRA1,
    input  logic [AW-1:0] ADDRB0,
    input  logic [AW-1:0] ADDRB1,
    input  logic [DW-1:0] WDATA0,
    input  logic [DW-1:0] WDATA1,
    output logic          ACK0,
    output logic          ACK1,
    output logic [DW-1:0] RDATA_A,
    output logic [DW-1:0] RDATA_B,
    output logic [AW-1:0] RF_ADDR_A,
    output logic [AW-1:0] RF_ADDR_B,
    output logic [DW-1:0] RF_DATA_IN,
    output logic          RF_WR,
    input  logic [DW-1:0] RF_SRC,
    input  logic [DW-1:0] RF_DEST
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic          idx;
        logic          we;
        logic [AW-1:0] addra;
        logic [AW-1:0] addrb;
        logic [DW-1:0] wdata;
    } txn_t;

    state_t        state, state_nxt;
    txn_t          txn, txn_nxt;
    logic          last, last_nxt;
    logic          win;
    logic          cap;
    logic [DW-1:0] rdata_a_q, rdata_b_q;

    // Winner among the currently raised requests; only consulted in IDLE.
    always_comb begin
`ifdef RF_ARB_FIXED_PRIO_EN
        win = ~REQ0;
`else
        win = (REQ0 && REQ1) ? ~last : REQ1;
`endif
    end

    always_comb begin
        state_nxt = state;
        txn_nxt   = txn;
        last_nxt  = last;
        cap       = 1'b0;
        case (state)
            IDLE: begin
                if (REQ0 || REQ1) begin
                    state_nxt   = ACCESS;
                    txn_nxt.idx = win;
                    if (win) begin
                        txn_nxt.we    = WE1;
                        txn_nxt.addra = ADDRA1;
                        txn_nxt.addrb = ADDRB1;
                        txn_nxt.wdata = WDATA1;
                    end else begin
                        txn_nxt.we    = WE0;
                        txn_nxt.addra = ADDRA0;
                        txn_nxt.addrb = ADDRB0;
                        txn_nxt.wdata = WDATA0;
                    end
                end
            end
            ACCESS: begin
                cap       = 1'b1;
                last_nxt  = txn.idx;
                state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            txn       <= '0;
            last      <= 1'b1;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state <= state_nxt;
            txn   <= txn_nxt;
            last  <= last_nxt;
            // Reads are combinational, so both values are pre-write at this edge.
            if (cap) begin
                rdata_a_q <= RF_SRC;
                rdata_b_q <= RF_DEST;
            end
        end
    end

    // The transaction register only changes on IDLE->ACCESS, so it doubles as the address/data hold.
    assign RF_ADDR_A  = txn.addra;
    assign RF_ADDR_B  = txn.addrb;
    assign RF_DATA_IN = txn.wdata;
    assign RF_WR      = (state == ACCESS) && txn.we && !RST;
    assign ACK0       = (state == DONE) && !txn.idx && !RST;
    assign ACK1       = (state == DONE) &&  txn.idx && !RST;
    assign RDATA_A    = rdata_a_q;
    assign RDATA_B    = rdata_b_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural 16x16 register file behind it.
module tb_regfile_arbiter;
    localparam int DW = 16;
    localparam int AW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          REQ0, REQ1, WE0, WE1;
    logic [AW-1:0] ADDRA0, ADDRA1, ADDRB0, ADDRB1;
    logic [DW-1:0] WDATA0, WDATA1;
    logic          ACK0, ACK1;
    logic [DW-1:0] RDATA_A, RDATA_B, RF_DATA_IN, RF_SRC, RF_DEST;
    logic [AW-1:0] RF_ADDR_A, RF_ADDR_B;
    logic          RF_WR;

    typedef struct {
        bit            idx;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] rf [16];
    logic [DW-1:0] mdl [16];
    bit            rf_clr;
    int            vectors = 0;
    int            miscompares = 0;

    regfile_arbiter #(.DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1), .WE0(WE0), .WE1(WE1),
        .ADDRA0(ADDRA0), .ADDRA1(ADDRA1), .ADDRB0(ADDRB0), .ADDRB1(ADDRB1),
        .WDATA0(WDATA0), .WDATA1(WDATA1),
        .ACK0(ACK0), .ACK1(ACK1), .RDATA_A(RDATA_A), .RDATA_B(RDATA_B),
        .RF_ADDR_A(RF_ADDR_A), .RF_ADDR_B(RF_ADDR_B), .RF_DATA_IN(RF_DATA_IN),
        .RF_WR(RF_WR), .RF_SRC(RF_SRC), .RF_DEST(RF_DEST)
    );

    always #5 CLK = ~CLK;

    assign RF_SRC  = rf[RF_ADDR_A];
    assign RF_DEST = rf[RF_ADDR_B];
    always @(posedge CLK) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
        end else if (RF_WR) begin
            rf[RF_ADDR_B] <= RF_DATA_IN;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Every ACK retires the oldest expectation.
    always @(negedge CLK) begin
        if (ACK0 && ACK1) begin
            chk("ack_both", 1, 0);
        end else if (ACK0 || ACK1) begin
            if (exp_q.size() == 0) begin
                chk("ack_unexpected", {ACK1, ACK0}, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ack_who", ACK1, e.idx);
                chk("rdata_a", RDATA_A, e.a);
                chk("rdata_b", RDATA_B, e.b);
            end
        end
    end

    task automatic drive(input bit idx, input bit we, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [DW-1:0] wd);
        if (idx) begin
            REQ1 = 1'b1; WE1 = we; ADDRA1 = a; ADDRB1 = b; WDATA1 = wd;
        end else begin
            REQ0 = 1'b1; WE0 = we; ADDRA0 = a; ADDRB0 = b; WDATA0 = wd;
        end
    endtask

    task automatic expect_access(input bit idx, input bit we, input logic [AW-1:0] a,
                                 input logic [AW-1:0] b, input logic [DW-1:0] wd);
        exp_t e;
        e.idx = idx;
        e.a   = mdl[a];
        e.b   = mdl[b];
        exp_q.push_back(e);
        if (we) mdl[b] = wd;
    endtask

    // Single access from an idle arbiter; checks latency and the write strobe.
    task automatic issue(input bit idx, input bit we, input logic [AW-1:0] a,
                         input logic [AW-1:0] b, input logic [DW-1:0] wd);
        int n    = 0;
        int wrs  = 0;
        bit got  = 0;
        @(negedge CLK);
        expect_access(idx, we, a, b, wd);
        drive(idx, we, a, b, wd);
        while (!got && n < 10) begin
            @(negedge CLK);
            n++;
            if (RF_WR) begin
                wrs++;
                chk("wr_addr", RF_ADDR_B, b);
                chk("wr_data", RF_DATA_IN, wd);
            end
            if ((idx && ACK1) || (!idx && ACK0)) got = 1;
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        chk("ack_seen", got, 1);
        chk("ack_latency", n, 2);
        chk("wr_cycles", wrs, we);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, {ACK1, ACK0}, 0);
        chk({tag, "_rf_wr"}, RF_WR, 0);
        chk({tag, "_rf_addr"}, {RF_ADDR_A, RF_ADDR_B}, 0);
        chk({tag, "_rf_din"}, RF_DATA_IN, 0);
        chk({tag, "_rdata"}, {RDATA_A, RDATA_B}, 0);
    endtask

    initial begin
        int n, acks, last_n;
        REQ0 = 0; REQ1 = 0; WE0 = 0; WE1 = 0;
        ADDRA0 = 0; ADDRA1 = 0; ADDRB0 = 0; ADDRB1 = 0; WDATA0 = 0; WDATA1 = 0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        RST = 1'b1;
        rf_clr = 1'b1;
        repeat (2) @(negedge CLK);
        chk_reset_outputs("por");
        RST = 1'b0;
        rf_clr = 1'b0;

        // Preload
        issue(0, 1, 0, 7, 16'h5678);
        issue(1, 1, 0, 4, 16'h0444);
        issue(0, 1, 0, 5, 16'h0555);
        issue(1, 1, 0, 2, 16'h2222);

        // Single write then read back
        issue(0, 1, 3, 1, 16'h1234);
        issue(1, 0, 1, 1, 16'h0000);

        // Read-during-write returns old contents
        issue(1, 1, 0, 7, 16'hABCD);
        issue(0, 0, 7, 7, 16'h0000);

        // Dual read, then addresses/data hold while idle
        issue(1, 0, 4, 5, 16'h0000);
        @(negedge CLK);
        chk("hold_addr", {RF_ADDR_A, RF_ADDR_B}, {4'd4, 4'd5});
        chk("hold_wr", RF_WR, 0);

        // Reset during ACCESS of a write to R2
        @(negedge CLK);
        drive(0, 1, 0, 2, 16'h9999);
        @(negedge CLK);
        chk("pre_rst_wr", RF_WR, 1);
        RST = 1'b1;
        REQ0 = 1'b0;
        #1 chk("rst_kills_wr", RF_WR, 0);
        repeat (2) begin
            @(negedge CLK);
            chk("rst_no_ack", {ACK1, ACK0}, 0);
        end
        chk_reset_outputs("midrst");
        RST = 1'b0;
        repeat (2) begin
            @(negedge CLK);
            chk("post_rst_no_ack", {ACK1, ACK0}, 0);
        end

        // Contention: both held, first arrival together right after reset
        @(negedge CLK);
        drive(0, 0, 4, 5, 16'hFFFF);
        drive(1, 1, 10, 10, 16'h0A0A);
        for (int k = 0; k < 4; k++) begin
`ifdef RF_ARB_FIXED_PRIO_EN
            expect_access(0, 0, 4, 5, 16'hFFFF);
`else
            if (k % 2 == 0) expect_access(0, 0, 4, 5, 16'hFFFF);
            else            expect_access(1, 1, 10, 10, 16'h0A0A);
`endif
        end
        n = 0; acks = 0; last_n = 0;
        while (acks < 4 && n < 40) begin
            @(negedge CLK);
            n++;
            if (ACK0 || ACK1) begin
                acks++;
                if (acks > 1) chk("ack_gap", n - last_n, 3);
                else          chk("first_ack_at", n, 2);
                last_n = n;
            end
        end
        REQ0 = 1'b0;
        REQ1 = 1'b0;
        chk("contention_acks", acks, 4);

        // R2 survived the cancelled write
        issue(1, 0, 2, 10, 16'h0000);

        repeat (4) @(negedge CLK);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
